socaudio_button_debounce: RTL and testbench

SOCAUDIO_BUTTON_DEBOUNCE -- requirements
Module: socaudio_button_debounce

---
 rtl/socaudio_button_debounce.sv | 93 +++++++++
 tb/tb_socaudio_button_debounce.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/socaudio_button_debounce.sv
// Per-channel debouncer for board keys: 2-flop synchroniser, stable-count filter, press strobe.
// Optional press strobe built only when SOCAUDIO_BTN_PRESS_PULSE_EN is defined.
module socaudio_button_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] press_pulse
);

  localparam logic             IDLE_BIT = (ACTIVE_LOW != 0);
  localparam logic [WIDTH-1:0] IDLE     = {WIDTH{IDLE_BIT}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StStable, StPending} state_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  state_e           state [WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      level_q <= IDLE;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // State is implied by whether the synchronised sample disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      state[i] = (sync2_q[i] == level_q[i]) ? StStable : StPending;
      unique case (state[i])
        StStable: cnt_d[i] = '0;
        StPending: begin
          if (cnt_q[i] == CNT_LAST) begin
            level_d[i] = sync2_q[i];
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  assign btn_level = level_q;

`ifdef SOCAUDIO_BTN_PRESS_PULSE_EN
  logic [WIDTH-1:0] pulse_q, pulse_d;

  // Registered alongside level so the strobe coincides with the first pressed cycle.
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pulse_d[i] = (level_d[i] != IDLE_BIT) && (level_q[i] == IDLE_BIT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;
`else
  assign press_pulse = '0;
`endif

endmodule

// File: tb/tb_socaudio_button_debounce.sv
// Bench for socaudio_button_debounce: directed literal scenarios plus randomized bouncing keys,
// checked every cycle against a run-length reference model.
module tb_socaudio_button_debounce;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEB   = 4;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned ALOW  = 1;
`ifdef SOCAUDIO_BTN_PRESS_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] btn_raw = '1;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] press_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  socaudio_button_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CNT_W),
    .ACTIVE_LOW(ALOW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: raw reaches the filter two edges late; a level is accepted once DEB
  // consecutive delayed samples disagree with it.
  logic [WIDTH-1:0] m_d1 = '1;
  logic [WIDTH-1:0] m_d2 = '1;
  logic [WIDTH-1:0] m_lvl = '1;
  logic [WIDTH-1:0] m_pulse = '0;
  int               m_run [WIDTH];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_d1 = '1;
      m_d2 = '1;
      m_lvl = '1;
      m_pulse = '0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end else begin
      logic [WIDTH-1:0] s;
      s = m_d2;
      m_d2 = m_d1;
      m_d1 = btn_raw;
      m_pulse = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= int'(DEB)) begin
            m_lvl[i] = s[i];
            m_run[i] = 0;
            if (s[i] == 1'b0) m_pulse[i] = PULSE_EN;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    cycle++;
    n_checks++;
    if (btn_level !== m_lvl) begin
      n_errors++;
      $display("FAIL cycle %0d btn_level got %h expected %h", cycle, btn_level, m_lvl);
    end
    n_checks++;
    if (press_pulse !== m_pulse) begin
      n_errors++;
      $display("FAIL cycle %0d press_pulse got %h expected %h", cycle, press_pulse, m_pulse);
    end
  end

  // Literal expectation checked against both DUT and model.
  task automatic check_lit(input string name, input logic [WIDTH-1:0] exp_lvl,
                           input logic [WIDTH-1:0] exp_pulse);
    logic [WIDTH-1:0] ep;
    ep = PULSE_EN ? exp_pulse : '0;
    n_checks++;
    if (btn_level !== exp_lvl || press_pulse !== ep) begin
      n_errors++;
      $display("FAIL %s dut level/pulse got %h/%h expected %h/%h", name, btn_level, press_pulse,
               exp_lvl, ep);
    end
    n_checks++;
    if (m_lvl !== exp_lvl || m_pulse !== ep) begin
      n_errors++;
      $display("FAIL %s model level/pulse got %h/%h expected %h/%h", name, m_lvl, m_pulse,
               exp_lvl, ep);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [WIDTH-1:0] v);
    #1 btn_raw = v;
  endtask

  int               hold [WIDTH];
  logic [WIDTH-1:0] rv;

  initial begin
    // Reset with keys released
    btn_raw = 4'hF;
    reset_n = 1'b0;
    negs(3);
    check_lit("reset_idle", 4'hF, 4'h0);
    #1 reset_n = 1'b1;
    negs(8);
    check_lit("idle_after_reset", 4'hF, 4'h0);

    // Single clean press on channel 0
    drive(4'hE);
    negs(5);
    check_lit("press0_before", 4'hF, 4'h0);
    negs(1);
    check_lit("press0_accept", 4'hE, 4'h1);
    negs(1);
    check_lit("press0_after", 4'hE, 4'h0);
    drive(4'hF);
    negs(6);
    check_lit("release0", 4'hF, 4'h0);

    // Glitch of 3 cycles on channel 1 is rejected
    drive(4'hD);
    negs(3);
    drive(4'hF);
    negs(10);
    check_lit("glitch1_rejected", 4'hF, 4'h0);
    // 4 cycles low is accepted
    drive(4'hD);
    negs(4);
    drive(4'hF);
    negs(1);
    check_lit("hold1_before", 4'hF, 4'h0);
    negs(1);
    check_lit("hold1_accept", 4'hD, 4'h2);
    negs(10);
    check_lit("hold1_released", 4'hF, 4'h0);

    // Simultaneous press on channels 0 and 3
    drive(4'h6);
    negs(5);
    check_lit("multi_before", 4'hF, 4'h0);
    negs(1);
    check_lit("multi_accept", 4'h6, 4'h9);
    negs(1);
    check_lit("multi_after", 4'h6, 4'h0);
    drive(4'hF);
    negs(6);
    check_lit("multi_release", 4'hF, 4'h0);

    // Reset mid-pending discards the count
    drive(4'hE);
    negs(4);
    #1 reset_n = 1'b0;
    negs(2);
    check_lit("reset_mid_pending", 4'hF, 4'h0);
    #1 reset_n = 1'b1;
    negs(5);
    check_lit("post_reset_before", 4'hF, 4'h0);
    negs(1);
    check_lit("post_reset_accept", 4'hE, 4'h1);
    drive(4'hF);
    negs(8);

    // Randomized bouncing keys with occasional resets
    for (int i = 0; i < WIDTH; i++) hold[i] = 0;
    rv = 4'hF;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (hold[i] == 0) begin
          rv[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 9);
        end
        hold[i]--;
      end
      #1 btn_raw = rv;
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        negs(1);
        #1 reset_n = 1'b1;
      end
      negs(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
